addition_round_stage: RTL
=========================

Name: addition_round_stage

Overview:
- Stage 5 of the single-precision adder: consumes the normalized sign/exponent/mantissa from the normalizer and produces the final packed IEEE-754 word.
- Performs guard/round/sticky rounding in one of four modes, handles renormalization after a rounding carry, overflow saturation and special values.
- Two-stage registered pipeline with valid/ready handshake on both sides.

Parameters:
- DATA_WIDTH, 32, packed result width (1+EXPO_WIDTH+MENT_WIDTH)
- MENT_WIDTH, 23, stored fraction width
- EXPO_WIDTH, 8, biased exponent width

Ports:
- clk_in  input  1  clock; all state on rising edge
- rst_n_in  input  1  reset, asynchronous, active-low
- valid_in  input  1  upstream result valid
- ready_out  output  1  stage can accept an input this cycle
- sign_in  input  1  result sign
- exponent_in  input  EXPO_WIDTH+1  biased exponent from normalizer; values >= 2^EXPO_WIDTH-1 mean overflow
- mentissa_in  input  MENT_WIDTH+4  {hidden, fraction[MENT_WIDTH-1:0], G, R, S}
- rmode_in  input  2  00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
- is_nan_in, is_inf_in, is_zero_in  input  1 each  special-case flags from upstream
- valid_out  output  1  result valid
- ready_in  input  1  downstream accepts result
- floating_addition_out  output  DATA_WIDTH  packed result
- inexact_out  output  1  result differs from exact value
- overflow_out  output  1  exponent overflow occurred

Behaviour:
- Reset (async assert, sync release): both pipe valids 0; valid_out=0, floating_addition_out=0, inexact_out=0, overflow_out=0. ready_out is 1 after reset. Reset mid-operation discards all in-flight data.
- Transfer in: valid_in && ready_out. Transfer out: valid_out && ready_in.
- Stage A (round) advances when empty or when stage B is empty/advancing. Stage B (pack) holds when valid_out && !ready_in. ready_out = !A_valid || !B_valid || ready_in. Bubbles collapse. No data loss or reorder.
- Latency: 2 cycles from input transfer to valid_out with ready_in=1. Throughput: 1 per cycle.
- While stalled, outputs and flags are stable.
- Stage A, rounding increment inc:
  - RNE: inc = G & (R | S | frac LSB)
  - RTZ: inc = 0
  - RUP: inc = !sign & (G|R|S)
  - RDN: inc = sign & (G|R|S)
  - Register rounded = {hidden, fraction} + inc (MENT_WIDTH+2 bits), plus exponent, sign, flags, rmode, and inexact = G|R|S.
- Stage B, renormalize:
  - If rounded MSB (bit MENT_WIDTH+1) is set: fraction = 0, exponent+1.
  - Else if exponent==0 and bit MENT_WIDTH is set: exponent = 1 (subnormal rounds up to normal).
- Overflow: final exponent >= 2^EXPO_WIDTH-1 → overflow_out=1, inexact_out=1. Result by mode:
  - RNE → ±inf
  - RTZ → ±max finite (exp 0xFE, fraction all ones)
  - RUP → +inf if positive, else -max
  - RDN → -inf if negative, else +max
- Specials, priority nan > inf > zero; override the normal and overflow paths; inexact_out=0, overflow_out=0:
  - NaN → 0x7FC00000
  - inf → {sign, 0xFF, 0}
  - zero → {sign, 0, 0}, mantissa ignored
- Normal result: {sign, exponent[EXPO_WIDTH-1:0], fraction}.

Test Plan:
- Sign 0, exp 127, mentissa {1, frac 0, G=1, R=0, S=0}, RNE → 0x3F800000, inexact=1 (tie to even). Same input with frac LSB=1 → 0x3F800002.
- Exp 127, frac all ones, G=1, R=1, RNE → carry renormalize → 0x40000000, inexact=1. Same input with RTZ → 0x3FFFFFFF.
- Exp 254, frac all ones, G=1: RNE → 0x7F800000, overflow=1. RTZ → 0x7F7FFFFF. Sign=1 with RUP → 0xFF7FFFFF.
- is_nan_in=1 together with is_inf_in=1 → 0x7FC00000, flags 0. is_zero_in with sign=1 and nonzero mantissa → 0x80000000.
- Back-to-back inputs A, B, C with ready_in low for 4 cycles → ready_out drops once both stages are full. Output A is held stable; when ready_in rises, A, B, C emerge on consecutive cycles in order.
- Assert rst_n_in with 2 items in flight → valid_out=0 immediately (asynchronous). After release, no stale results appear and the first new input appears after 2 cycles.

Source files
------------

// File: rtl/addition_round_stage.sv
// Final stage of the single-precision adder: rounds the normalized mantissa,
// renormalizes, saturates on overflow and packs the IEEE-754 result.
module addition_round_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic                    sign_in,
  input  logic [EXPO_WIDTH:0]     exponent_in,
  input  logic [MENT_WIDTH+3:0]   mentissa_in,
  input  logic [1:0]              rmode_in,
  input  logic                    is_nan_in,
  input  logic                    is_inf_in,
  input  logic                    is_zero_in,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic [DATA_WIDTH-1:0]   floating_addition_out,
  output logic                    inexact_out,
  output logic                    overflow_out
);

  localparam int RW = MENT_WIDTH + 2;
  localparam int EW = EXPO_WIDTH + 2;
  localparam logic [EW-1:0] EXP_LIMIT = {2'b00, {EXPO_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    RNE = 2'b00,
    RTZ = 2'b01,
    RUP = 2'b10,
    RDN = 2'b11
  } rmode_e;

  logic                  aValid_q, aValid_d;
  logic                  aSign_q;
  logic [EXPO_WIDTH:0]   aExp_q;
  logic [RW-1:0]         aRounded_q, aRounded_d;
  logic                  aInexact_q, aInexact_d;
  logic                  aNan_q, aInf_q, aZero_q;
  logic [1:0]            aRmode_q;

  logic                  bValid_q, bValid_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  inexact_q, inexact_d;
  logic                  overflow_q, overflow_d;

  logic advanceA, advanceB;
  logic guardBit, roundBit, stickyBit, lsbBit, roundInc;

  assign advanceB  = !bValid_q || ready_in;
  assign advanceA  = !aValid_q || advanceB;
  assign ready_out = advanceA;
  assign aValid_d  = advanceA ? valid_in : aValid_q;
  assign bValid_d  = advanceB ? aValid_q : bValid_q;

  assign lsbBit     = mentissa_in[3];
  assign guardBit   = mentissa_in[2];
  assign roundBit   = mentissa_in[1];
  assign stickyBit  = mentissa_in[0];
  assign aInexact_d = guardBit | roundBit | stickyBit;

  always_comb begin
    roundInc = 1'b0;
    case (rmode_e'(rmode_in))
      RNE: roundInc = guardBit & (roundBit | stickyBit | lsbBit);
      RTZ: roundInc = 1'b0;
      RUP: roundInc = !sign_in & aInexact_d;
      RDN: roundInc = sign_in & aInexact_d;
      default: roundInc = 1'b0;
    endcase
  end

  assign aRounded_d = {1'b0, mentissa_in[MENT_WIDTH+3:3]} + {{(RW-1){1'b0}}, roundInc};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      aValid_q   <= 1'b0;
      aSign_q    <= 1'b0;
      aExp_q     <= '0;
      aRounded_q <= '0;
      aInexact_q <= 1'b0;
      aNan_q     <= 1'b0;
      aInf_q     <= 1'b0;
      aZero_q    <= 1'b0;
      aRmode_q   <= 2'b00;
    end else begin
      aValid_q <= aValid_d;
      if (advanceA && valid_in) begin
        aSign_q    <= sign_in;
        aExp_q     <= exponent_in;
        aRounded_q <= aRounded_d;
        aInexact_q <= aInexact_d;
        aNan_q     <= is_nan_in;
        aInf_q     <= is_inf_in;
        aZero_q    <= is_zero_in;
        aRmode_q   <= rmode_in;
      end
    end
  end

  logic [EW-1:0]         expFinal;
  logic [MENT_WIDTH-1:0] fracFinal;
  logic                  expOverflow;
  logic [DATA_WIDTH-1:0] infWord, maxWord;

  // A rounding carry leaves rounded = 10...0, so the fraction is zero.
  always_comb begin
    expFinal  = {1'b0, aExp_q};
    fracFinal = aRounded_q[MENT_WIDTH-1:0];
    if (aRounded_q[MENT_WIDTH+1]) begin
      expFinal  = {1'b0, aExp_q} + {{(EW-1){1'b0}}, 1'b1};
      fracFinal = '0;
    end else if (aExp_q == '0 && aRounded_q[MENT_WIDTH]) begin
      expFinal = {{(EW-1){1'b0}}, 1'b1};
    end
  end

  assign expOverflow = (expFinal >= EXP_LIMIT);
  assign infWord = {aSign_q, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
  assign maxWord = {aSign_q, {(EXPO_WIDTH-1){1'b1}}, 1'b0, {MENT_WIDTH{1'b1}}};

  always_comb begin
    result_d   = {aSign_q, expFinal[EXPO_WIDTH-1:0], fracFinal};
    inexact_d  = aInexact_q;
    overflow_d = 1'b0;
    if (aNan_q) begin
      result_d  = {1'b0, {EXPO_WIDTH{1'b1}}, 1'b1, {(MENT_WIDTH-1){1'b0}}};
      inexact_d = 1'b0;
    end else if (aInf_q) begin
      result_d  = infWord;
      inexact_d = 1'b0;
    end else if (aZero_q) begin
      result_d  = {aSign_q, {(DATA_WIDTH-1){1'b0}}};
      inexact_d = 1'b0;
    end else if (expOverflow) begin
      inexact_d  = 1'b1;
      overflow_d = 1'b1;
      case (rmode_e'(aRmode_q))
        RNE: result_d = infWord;
        RTZ: result_d = maxWord;
        RUP: result_d = aSign_q ? maxWord : infWord;
        RDN: result_d = aSign_q ? infWord : maxWord;
        default: result_d = infWord;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bValid_q   <= 1'b0;
      result_q   <= '0;
      inexact_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      bValid_q <= bValid_d;
      if (advanceB && aValid_q) begin
        result_q   <= result_d;
        inexact_q  <= inexact_d;
        overflow_q <= overflow_d;
      end
    end
  end

  assign valid_out             = bValid_q;
  assign floating_addition_out = result_q;
  assign inexact_out           = inexact_q;
  assign overflow_out          = overflow_q;

endmodule
